// File: rtl/rv_pkg.sv
// Shared definitions for the RV32I pipeline: datapath width, bubble encoding,
// reset vector and the word-alignment helpers used by redirect logic.
package rv_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] ALIGN_MASK       = 32'hFFFF_FFFC;

    // A redirect target is misaligned when either of its low two bits is set.
    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return |addr[1:0];
    endfunction

endpackage

// File: rtl/pipe_reg_en_clr.sv
// Generic pipeline register: synchronous reset and clear both load RESET_VAL,
// enable gates normal capture. Priority is reset, then clear, then enable.
module pipe_reg_en_clr #(
    parameter int          WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RESET_VAL;
        end else if (clr) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register with redirect/stall handling, the PC+4
// adder, and the IF/ID register that feeds decode.
module fetch_stage
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = rv_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = rv_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        pc_src_e,
    input  logic [31:0] pc_target_e,
    input  logic [31:0] instr_f,
    output logic [31:0] pc_f,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic [31:0] instr_d,
    output logic        valid_d,
    output logic        misalign_err
);

    logic [XLEN-1:0] pc_plus4_f;
    logic [XLEN-1:0] pc_next;
    logic            pc_en;
    logic            d_en;

    assign pc_plus4_f = pc_f + 32'd4;
    assign pc_next    = pc_src_e ? (pc_target_e & ALIGN_MASK) : pc_plus4_f;
    // A redirect must land even while fetch is stalled, otherwise it is lost.
    assign pc_en      = pc_src_e | ~stall_f;
    assign d_en       = ~stall_d;

    pipe_reg_en_clr #(.WIDTH(XLEN), .RESET_VAL(RESET_PC)) u_pc_reg (
        .clk   (clk),
        .reset (reset),
        .en    (pc_en),
        .clr   (1'b0),
        .d     (pc_next),
        .q     (pc_f)
    );

    pipe_reg_en_clr #(.WIDTH(XLEN), .RESET_VAL(32'h0)) u_pc_d_reg (
        .clk   (clk),
        .reset (reset),
        .en    (d_en),
        .clr   (flush_d),
        .d     (pc_f),
        .q     (pc_d)
    );

    pipe_reg_en_clr #(.WIDTH(XLEN), .RESET_VAL(32'h0)) u_pc_plus4_d_reg (
        .clk   (clk),
        .reset (reset),
        .en    (d_en),
        .clr   (flush_d),
        .d     (pc_plus4_f),
        .q     (pc_plus4_d)
    );

    pipe_reg_en_clr #(.WIDTH(XLEN), .RESET_VAL(NOP_INSTR)) u_instr_d_reg (
        .clk   (clk),
        .reset (reset),
        .en    (d_en),
        .clr   (flush_d),
        .d     (instr_f),
        .q     (instr_d)
    );

    pipe_reg_en_clr #(.WIDTH(1), .RESET_VAL(1'b0)) u_valid_d_reg (
        .clk   (clk),
        .reset (reset),
        .en    (d_en),
        .clr   (flush_d),
        .d     (1'b1),
        .q     (valid_d)
    );

    // Sticky until reset so software/debug can observe that a bad target occurred.
    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_err <= 1'b0;
        end else if (pc_src_e && is_misaligned(pc_target_e)) begin
            misalign_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: stimulus pushes hand-computed expectations
// tagged with a cycle number; a negedge monitor pops and compares them.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall_f;
    logic        stall_d;
    logic        flush_d;
    logic        pc_src_e;
    logic [31:0] pc_target_e;
    logic [31:0] instr_f;
    logic [31:0] pc_f;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic [31:0] instr_d;
    logic        valid_d;
    logic        misalign_err;

    typedef struct {
        int          cyc;
        string       name;
        logic [31:0] pcF;
        logic [31:0] pcD;
        logic [31:0] pcPlus4D;
        logic [31:0] instrD;
        logic        validD;
        logic        misErr;
    } expect_t;

    expect_t     expQueue[$];
    int          cyc = 0;
    int          checksTotal = 0;
    int          checksPassed = 0;
    logic [31:0] mem [0:63];

    fetch_stage dut (
        .clk          (clk),
        .reset        (reset),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .flush_d      (flush_d),
        .pc_src_e     (pc_src_e),
        .pc_target_e  (pc_target_e),
        .instr_f      (instr_f),
        .pc_f         (pc_f),
        .pc_d         (pc_d),
        .pc_plus4_d   (pc_plus4_d),
        .instr_d      (instr_d),
        .valid_d      (valid_d),
        .misalign_err (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Combinational instruction memory model.
    assign instr_f = mem[pc_f[7:2]];

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + 32'(i);
        mem[0] = 32'hFFC4_A283;
        mem[1] = 32'h0062_E233;
    end

    task automatic compareField(input string name, input string field,
                                input logic [31:0] act, input logic [31:0] req);
        checksTotal++;
        if (act === req) checksPassed++;
        else $display("[TB] FAIL %s.%s: got %08h, required %08h", name, field, act, req);
    endtask

    task automatic checkOutput(input expect_t e);
        compareField(e.name, "pc_f",       pc_f,               e.pcF);
        compareField(e.name, "pc_d",       pc_d,               e.pcD);
        compareField(e.name, "pc_plus4_d", pc_plus4_d,         e.pcPlus4D);
        compareField(e.name, "instr_d",    instr_d,            e.instrD);
        compareField(e.name, "valid_d",    {31'b0, valid_d},   {31'b0, e.validD});
        compareField(e.name, "misalign",   {31'b0, misalign_err}, {31'b0, e.misErr});
    endtask

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge clk) begin
        while (expQueue.size() > 0 && expQueue[0].cyc <= cyc) begin
            expect_t e;
            e = expQueue.pop_front();
            if (e.cyc < cyc) begin
                checksTotal++;
                $display("[TB] FAIL %s: expectation for cycle %0d seen at cycle %0d", e.name, e.cyc, cyc);
            end else begin
                checkOutput(e);
            end
        end
    end

    task automatic applyStimulus(input logic rst, input logic sf, input logic sd,
                                 input logic fl, input logic src, input logic [31:0] tgt);
        reset       = rst;
        stall_f     = sf;
        stall_d     = sd;
        flush_d     = fl;
        pc_src_e    = src;
        pc_target_e = tgt;
        @(posedge clk);
        #1;
    endtask

    // Queue the state expected after the edge just taken; plus4 of a bubble is 0.
    task automatic expectNow(input string name, input logic [31:0] pcF, input logic [31:0] pcD,
                             input logic [31:0] instrD, input logic validD, input logic misErr);
        expect_t e;
        e.cyc      = cyc;
        e.name     = name;
        e.pcF      = pcF;
        e.pcD      = pcD;
        e.pcPlus4D = validD ? pcD + 32'd4 : 32'h0;
        e.instrD   = instrD;
        e.validD   = validD;
        e.misErr   = misErr;
        expQueue.push_back(e);
    endtask

    initial begin
        reset = 1'b1; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
        pc_src_e = 1'b0; pc_target_e = 32'h0;

        applyStimulus(1, 0, 0, 0, 0, 32'h0);
        expectNow("reset1", 32'h0, 32'h0, 32'h13, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 32'h0);
        expectNow("reset2", 32'h0, 32'h0, 32'h13, 0, 0);

        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        expectNow("fetch0", 32'h4, 32'h0, 32'hFFC4_A283, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        expectNow("fetch4", 32'h8, 32'h4, 32'h0062_E233, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        expectNow("fetch8", 32'hC, 32'h8, 32'hA000_0002, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        expectNow("at18", 32'h18, 32'h14, 32'hA000_0005, 1, 0);

        applyStimulus(0, 1, 1, 0, 0, 32'h0);
        expectNow("loaduse", 32'h18, 32'h14, 32'hA000_0005, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        expectNow("release", 32'h1C, 32'h18, 32'hA000_0006, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        expectNow("at24", 32'h24, 32'h20, 32'hA000_0008, 1, 0);

        applyStimulus(0, 1, 0, 1, 1, 32'h0);
        expectNow("branch", 32'h0, 32'h0, 32'h13, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        expectNow("postbranch", 32'h4, 32'h0, 32'hFFC4_A283, 1, 0);

        applyStimulus(0, 0, 1, 1, 0, 32'h0);
        expectNow("flushvsstall", 32'h8, 32'h0, 32'h13, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 32'h0);
        expectNow("stallfonly", 32'h8, 32'h8, 32'hA000_0002, 1, 0);
        applyStimulus(0, 0, 1, 0, 0, 32'h0);
        expectNow("stalldonly", 32'hC, 32'h8, 32'hA000_0002, 1, 0);

        applyStimulus(0, 0, 0, 0, 1, 32'h1E);
        expectNow("misalign", 32'h1C, 32'hC, 32'hA000_0003, 1, 1);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 32'h0);
            expectNow($sformatf("sticky%0d", k), 32'h20 + 32'(4 * k), 32'h1C + 32'(4 * k),
                      32'hA000_0007 + 32'(k), 1, 1);
        end

        applyStimulus(1, 1, 0, 1, 1, 32'h30);
        expectNow("midreset", 32'h0, 32'h0, 32'h13, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        expectNow("postreset", 32'h4, 32'h0, 32'hFFC4_A283, 1, 0);

        applyStimulus(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        expectNow("tolast", 32'hFFFF_FFFC, 32'h4, 32'h0062_E233, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        expectNow("wrap", 32'h0, 32'hFFFF_FFFC, 32'hA000_003F, 1, 0);

        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        while (expQueue.size() > 0) begin
            expect_t e;
            e = expQueue.pop_front();
            checksTotal++;
            $display("[TB] FAIL %s: expectation for cycle %0d never checked", e.name, e.cyc);
        end

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
